// File: rtl/fpu_add_sub_issue.sv
// Operand-issue stage for the binary32 add/sub core: unpacks and classifies both
// operands, resolves the rounding mode, and buffers results in a 2-entry skid FIFO.
module fpu_add_sub_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      opA_i,
    input  logic [31:0]      opB_i,
    input  logic             sub_i,
    input  logic [2:0]       rm_i,
    input  logic [2:0]       frm_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             sign_A_o,
    output logic             sign_B_o,
    output logic [7:0]       exp_A_o,
    output logic [7:0]       exp_B_o,
    output logic [23:0]      sig_A_o,
    output logic [23:0]      sig_B_o,
    output logic             isZeroA_o,
    output logic             isZeroB_o,
    output logic             isInfA_o,
    output logic             isInfB_o,
    output logic             isNaNA_o,
    output logic             isNaNB_o,
    output logic             isSignaling_o,
    output logic             sub_op_o,
    output logic [2:0]       rounding_mode_o,
    output logic             illegal_rm_o,
    output logic [TAG_W-1:0] tag_o
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        zero;
        logic        inf;
        logic        nan;
        logic        snan;
    } opnd_t;

    typedef struct packed {
        logic             sign_a;
        logic [7:0]       exp_a;
        logic [23:0]      sig_a;
        logic             zero_a;
        logic             inf_a;
        logic             nan_a;
        logic             sign_b;
        logic [7:0]       exp_b;
        logic [23:0]      sig_b;
        logic             zero_b;
        logic             inf_b;
        logic             nan_b;
        logic             signaling;
        logic             sub_op;
        logic [2:0]       rm;
        logic             illegal_rm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    function automatic opnd_t unpack(input logic [31:0] raw);
        opnd_t o;
        logic  frac_nz;
        logic  exp_max;
        frac_nz = |raw[22:0];
        exp_max = &raw[30:23];
        o.sign  = raw[31];
        o.exp   = raw[30:23];
        o.sig   = {|raw[30:23], raw[22:0]};
        o.zero  = (raw[30:23] == 8'd0) && !frac_nz;
        o.inf   = exp_max && !frac_nz;
        o.nan   = exp_max && frac_nz;
        // Quiet bit clear on a NaN marks it signaling.
        o.snan  = exp_max && frac_nz && !raw[22];
        return o;
    endfunction

    logic [1:0] count_q, count_d;
    entry_t     head_q, head_d;
    entry_t     slot1_q, slot1_d;
    entry_t     in_entry;
    opnd_t      ua, ub;
    logic [2:0] rm_res;
    logic       push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    assign ua     = unpack(opA_i);
    assign ub     = unpack(opB_i);
    assign rm_res = (rm_i == 3'b111) ? frm_i : rm_i;

    always_comb begin
        in_entry.sign_a     = ua.sign;
        in_entry.exp_a      = ua.exp;
        in_entry.sig_a      = ua.sig;
        in_entry.zero_a     = ua.zero;
        in_entry.inf_a      = ua.inf;
        in_entry.nan_a      = ua.nan;
        in_entry.sign_b     = ub.sign;
        in_entry.exp_b      = ub.exp;
        in_entry.sig_b      = ub.sig;
        in_entry.zero_b     = ub.zero;
        in_entry.inf_b      = ub.inf;
        in_entry.nan_b      = ub.nan;
        in_entry.signaling  = ua.snan | ub.snan;
        in_entry.sub_op     = sub_i;
        in_entry.rm         = rm_res;
        in_entry.illegal_rm = rm_res[2] & (rm_res[1] | rm_res[0]);
        in_entry.tag        = tag_i;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        head_d  = head_q;
        slot1_d = slot1_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d  = in_entry;
                    else                 slot1_d = in_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                // Only reachable with one entry held: the new op replaces the departing head.
                2'b11:   head_d = in_entry;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            // NOTE: payload slots are cleared too so every data output reads 0 straight out of reset.
            count_q <= 2'd0;
            head_q  <= '0;
            slot1_q <= '0;
        end else begin
            // NOTE: non-blocking updates so all state moves together on the edge.
            count_q <= count_d;
            head_q  <= head_d;
            slot1_q <= slot1_d;
        end
    end

    assign sign_A_o        = head_q.sign_a;
    assign sign_B_o        = head_q.sign_b;
    assign exp_A_o         = head_q.exp_a;
    assign exp_B_o         = head_q.exp_b;
    assign sig_A_o         = head_q.sig_a;
    assign sig_B_o         = head_q.sig_b;
    assign isZeroA_o       = head_q.zero_a;
    assign isZeroB_o       = head_q.zero_b;
    assign isInfA_o        = head_q.inf_a;
    assign isInfB_o        = head_q.inf_b;
    assign isNaNA_o        = head_q.nan_a;
    assign isNaNB_o        = head_q.nan_b;
    assign isSignaling_o   = head_q.signaling;
    assign sub_op_o        = head_q.sub_op;
    assign rounding_mode_o = head_q.rm;
    assign illegal_rm_o    = head_q.illegal_rm;
    assign tag_o           = head_q.tag;

endmodule

// File: tb/tb_fpu_add_sub_issue.sv
// Self-checking bench for fpu_add_sub_issue: directed vector table, stall/flush
// sequences, then randomized traffic against a queue-based reference model.
module tb_fpu_add_sub_issue;

    typedef struct packed {
        logic        sa, sb;
        logic [7:0]  ea, eb;
        logic [23:0] siga, sigb;
        logic        za, zb, ia, ib, na, nb;
        logic        sg, sub;
        logic [2:0]  rm;
        logic        ill;
        logic [4:0]  tag;
    } head_t;

    typedef struct {
        logic [31:0] a, b;
        logic        sub;
        logic [2:0]  rm, frm;
        logic [4:0]  tag;
        head_t       exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset_i, in_valid_i, in_ready_o, sub_i, flush_i, out_valid_o, out_ready_i;
    logic [31:0] opA_i, opB_i;
    logic [2:0]  rm_i, frm_i, rounding_mode_o;
    logic [4:0]  tag_i, tag_o;
    logic        sign_A_o, sign_B_o, isZeroA_o, isZeroB_o, isInfA_o, isInfB_o;
    logic        isNaNA_o, isNaNB_o, isSignaling_o, sub_op_o, illegal_rm_o;
    logic [7:0]  exp_A_o, exp_B_o;
    logic [23:0] sig_A_o, sig_B_o;
    head_t       act_head;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    fpu_add_sub_issue #(.TAG_W(5)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opA_i(opA_i), .opB_i(opB_i), .sub_i(sub_i), .rm_i(rm_i), .frm_i(frm_i), .tag_i(tag_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sign_A_o(sign_A_o), .sign_B_o(sign_B_o), .exp_A_o(exp_A_o), .exp_B_o(exp_B_o),
        .sig_A_o(sig_A_o), .sig_B_o(sig_B_o), .isZeroA_o(isZeroA_o), .isZeroB_o(isZeroB_o),
        .isInfA_o(isInfA_o), .isInfB_o(isInfB_o), .isNaNA_o(isNaNA_o), .isNaNB_o(isNaNB_o),
        .isSignaling_o(isSignaling_o), .sub_op_o(sub_op_o), .rounding_mode_o(rounding_mode_o),
        .illegal_rm_o(illegal_rm_o), .tag_o(tag_o)
    );

    assign act_head = {sign_A_o, sign_B_o, exp_A_o, exp_B_o, sig_A_o, sig_B_o,
                       isZeroA_o, isZeroB_o, isInfA_o, isInfB_o, isNaNA_o, isNaNB_o,
                       isSignaling_o, sub_op_o, rounding_mode_o, illegal_rm_o, tag_o};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic head_t mk(input logic sa, sb, input logic [7:0] ea, eb,
                                 input logic [23:0] siga, sigb, input logic [5:0] cls,
                                 input logic sg, sub, input logic [2:0] rm,
                                 input logic ill, input logic [4:0] tag);
        head_t h;
        h.sa = sa; h.sb = sb; h.ea = ea; h.eb = eb; h.siga = siga; h.sigb = sigb;
        {h.za, h.zb, h.ia, h.ib, h.na, h.nb} = cls;
        h.sg = sg; h.sub = sub; h.rm = rm; h.ill = ill; h.tag = tag;
        return h;
    endfunction

    // Reference: classify from the numeric value of each field using plain arithmetic.
    localparam int unsigned HIDDEN = 32'd8388608;   // 2^23
    localparam int unsigned QUIET  = 32'd4194304;   // 2^22

    function automatic head_t ref_entry(input logic [31:0] a, b, input logic sub,
                                        input logic [2:0] rm, frm, input logic [4:0] tag);
        head_t       h;
        int unsigned va, vb, ea, eb, fa, fb, res;
        va = a; vb = b;
        ea = (va / HIDDEN) % 256; fa = va % HIDDEN;
        eb = (vb / HIDDEN) % 256; fb = vb % HIDDEN;
        h.sa   = (va >= 32'h8000_0000);
        h.sb   = (vb >= 32'h8000_0000);
        h.ea   = 8'(ea);
        h.eb   = 8'(eb);
        h.siga = 24'((ea != 0 ? HIDDEN : 0) + fa);
        h.sigb = 24'((eb != 0 ? HIDDEN : 0) + fb);
        h.za   = (ea == 0) && (fa == 0);
        h.zb   = (eb == 0) && (fb == 0);
        h.ia   = (ea == 255) && (fa == 0);
        h.ib   = (eb == 255) && (fb == 0);
        h.na   = (ea == 255) && (fa != 0);
        h.nb   = (eb == 255) && (fb != 0);
        h.sg   = (h.na && fa < QUIET) || (h.nb && fb < QUIET);
        h.sub  = sub;
        res    = (rm == 3'd7) ? frm : rm;
        h.rm   = 3'(res);
        h.ill  = (res >= 5);
        h.tag  = tag;
        return h;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[30:0]  = '0;
            1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2: r[30:23] = 8'hFF;
            3: r[30:23] = 8'h00;
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, b, input logic sub,
                         input logic [2:0] rm, frm, input logic [4:0] tag);
        in_valid_i = v; opA_i = a; opB_i = b; sub_i = sub; rm_i = rm; frm_i = frm; tag_i = tag;
    endtask

    vec_t  vecs[6];
    head_t model_q[$];

    initial begin
        vecs[0] = '{32'h3F80_0000, 32'h0000_0001, 1'b1, 3'd0, 3'd0, 5'h11,
                    mk(0, 0, 8'h7F, 8'h00, 24'h800000, 24'h000001, 6'b000000, 0, 1, 3'd0, 0, 5'h11)};
        vecs[1] = '{32'h7FA0_0000, 32'hFF80_0000, 1'b0, 3'd1, 3'd0, 5'h12,
                    mk(0, 1, 8'hFF, 8'hFF, 24'hA00000, 24'h800000, 6'b000110, 1, 0, 3'd1, 0, 5'h12)};
        vecs[2] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 3'd7, 3'd3, 5'h13,
                    mk(0, 1, 8'h00, 8'h00, 24'h000000, 24'h000000, 6'b110000, 0, 1, 3'd3, 0, 5'h13)};
        vecs[3] = '{32'h7FC0_0000, 32'h4049_0FDB, 1'b0, 3'd5, 3'd2, 5'h14,
                    mk(0, 0, 8'hFF, 8'h80, 24'hC00000, 24'hC90FDB, 6'b000010, 0, 0, 3'd5, 1, 5'h14)};
        vecs[4] = '{32'h7F80_0000, 32'hFFFF_FFFF, 1'b1, 3'd7, 3'd7, 5'h15,
                    mk(0, 1, 8'hFF, 8'hFF, 24'h800000, 24'hFFFFFF, 6'b001001, 0, 1, 3'd7, 1, 5'h15)};
        vecs[5] = '{32'h0040_0000, 32'hFF80_0001, 1'b0, 3'd6, 3'd1, 5'h16,
                    mk(0, 1, 8'h00, 8'hFF, 24'h400000, 24'h800001, 6'b000001, 1, 0, 3'd6, 1, 5'h16)};

        // Reset held with a valid op offered: nothing may be accepted.
        reset_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 3'd2, 3'd0, 5'd7);
        repeat (3) @(negedge clk_i);
        check("reset_out_valid", 128'(out_valid_o), 128'(1'b0));
        check("reset_in_ready", 128'(in_ready_o), 128'(1'b1));
        check("reset_head_zero", 128'(act_head), 128'(0));
        reset_i = 1'b1;
        @(negedge clk_i);
        check("first_accept_valid", 128'(out_valid_o), 128'(1'b1));
        check("first_accept_tag", 128'(tag_o), 128'(5'd7));

        // Directed vectors, streamed back-to-back with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].rm, vecs[i].frm, vecs[i].tag);
            @(negedge clk_i);
            check($sformatf("vec%0d_valid", i), 128'(out_valid_o), 128'(1'b1));
            check($sformatf("vec%0d_head", i), 128'(act_head), 128'(vecs[i].exp));
        end
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("drain_valid", 128'(out_valid_o), 128'(1'b0));

        // Backpressure: three offers against a stalled consumer.
        out_ready_i = 1'b0;
        drive(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'd0, 3'd0, 5'd1);
        @(negedge clk_i);
        check("stall_ready_1", 128'(in_ready_o), 128'(1'b1));
        tag_i = 5'd2;
        @(negedge clk_i);
        check("stall_ready_full", 128'(in_ready_o), 128'(1'b0));
        check("stall_head_1", 128'(tag_o), 128'(5'd1));
        tag_i = 5'd3;
        @(negedge clk_i);
        check("stall_ready_held", 128'(in_ready_o), 128'(1'b0));
        check("stall_head_stable", 128'(tag_o), 128'(5'd1));
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("order_tag2", 128'(tag_o), 128'(5'd2));
        check("order_valid2", 128'(out_valid_o), 128'(1'b1));
        @(negedge clk_i);
        check("order_tag3", 128'(tag_o), 128'(5'd3));
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("order_empty", 128'(out_valid_o), 128'(1'b0));

        // Flush with the FIFO full and a simultaneous offer.
        out_ready_i = 1'b0;
        drive(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 3'd0, 3'd0, 5'd4);
        @(negedge clk_i);
        tag_i = 5'd5;
        @(negedge clk_i);
        check("flush_pre_full", 128'(in_ready_o), 128'(1'b0));
        flush_i = 1'b1; tag_i = 5'd6;
        @(negedge clk_i);
        check("flush_full_valid", 128'(out_valid_o), 128'(1'b0));
        check("flush_full_ready", 128'(in_ready_o), 128'(1'b1));
        // Flush with one entry held, where the offer would otherwise be accepted.
        flush_i = 1'b0; tag_i = 5'd8;
        @(negedge clk_i);
        flush_i = 1'b1; tag_i = 5'd9;
        @(negedge clk_i);
        check("flush_push_dropped", 128'(out_valid_o), 128'(1'b0));
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("flush_stays_empty", 128'(out_valid_o), 128'(1'b0));
        end

        // Randomized traffic against the queue model.
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk_i);
            check("rand_out_valid", 128'(out_valid_o), 128'(model_q.size() != 0));
            check("rand_in_ready", 128'(in_ready_o), 128'(model_q.size() < 2));
            if (model_q.size() != 0) check("rand_head", 128'(act_head), 128'(model_q[0]));
            drive($urandom_range(0, 9) < 7, rand_op(), rand_op(), 1'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom));
            out_ready_i = $urandom_range(0, 9) < 6;
            flush_i     = $urandom_range(0, 39) == 0;
            @(posedge clk_i);
            if (flush_i) begin
                model_q.delete();
            end else begin
                bit do_push, do_pop;
                do_push = in_valid_i && (model_q.size() < 2);
                do_pop  = out_ready_i && (model_q.size() != 0);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back(ref_entry(opA_i, opB_i, sub_i, rm_i, frm_i, tag_i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
